lda_accel_ms: RTL and testbench
===============================

Name: lda_accel_ms

Overview:
- Parametrised Avalon-MM line-drawing accelerator, the successor to the existing fixed 9/8-bit line peripheral.
- Host writes the endpoints and colour, then triggers GO. An internal Bresenham engine emits one pixel per cycle over a valid/ready stream to a framebuffer or VGA writer.
- Supports stall mode (the GO write is held by waitrequest) and poll mode (status register plus interrupt).
- Sits between the Nios/Avalon fabric and the pixel writer.

Parameters:
- X_W, 9: x coordinate width.
- Y_W, 8: y coordinate width; X_W+Y_W must be at most 32.
- COLOUR_W, 3: colour width, at most 32.
- EW, derived as max(X_W,Y_W)+2: signed width of the internal error and delta terms. Not overridable.

Ports:
- csi_clockreset_clk  in  1  sole clock.
- csi_clockreset_reset_n  in  1  asynchronous active-low reset.
- avs_s1_chipselect  in  1  slave select.
- avs_s1_address  in  3  word address.
- avs_s1_read  in  1  read strobe.
- avs_s1_write  in  1  write strobe.
- avs_s1_writedata  in  32  write data.
- avs_s1_readdata  out  32  read data, combinational, valid while read is asserted and waitrequest is low.
- avs_s1_waitrequest  out  1  stall to the master.
- pix_x  out  X_W  pixel x.
- pix_y  out  Y_W  pixel y.
- pix_colour  out  COLOUR_W  pixel colour.
- pix_valid  out  1  pixel present.
- pix_ready  in  1  sink accepts the pixel.
- irq  out  1  done interrupt, level.

Behaviour:
- Register map; all accesses require chipselect.
  - 0 MODE (rw): bit0 = poll (1) / stall (0); bit1 = irq_en.
  - 1 STATUS: read returns bit0 busy, bit1 done; writing 1 to bit1 clears done.
  - 2 GO (w): any write data.
  - 3 START (rw): x0 in [X_W-1:0], y0 in [X_W+Y_W-1:X_W].
  - 4 END (rw): x1 and y1, same packing.
  - 5 COLOUR (rw): [COLOUR_W-1:0].
  - 6 PIXCNT: see Optional Feature.
  - 7: reads 0, writes ignored.
  - Unused read bits are 0.
- Reset: all registers, MODE, done, irq, pix_valid, waitrequest and FSM go to 0 / IDLE. Reset is asynchronous and can abort a line in progress; pix_valid drops immediately.
- Engine FSM states IDLE, INIT, DRAW.
  - IDLE to INIT: on an accepted GO write.
  - INIT: latches x0/y0/x1/y1/colour; computes steep = |dy| > |dx|; swaps so the major axis steps; sets step signs; sets err = major/2 (floored).
  - DRAW: pix_valid = 1. On pix_valid & pix_ready:
    - if the current point equals the endpoint, set done, busy = 0, go to IDLE;
    - otherwise step the major axis and apply err -= minor; if err < 0, step the minor axis and add major.
  - Outputs are held stable while pix_ready is low.
- Lines are inclusive of both endpoints. Pixel count = max(|x1-x0|, |y1-y0|) + 1. All octants are supported.
- Latency: GO accepted in cycle N, INIT in N+1, first pix_valid in N+2. Throughput is 1 pixel/cycle with pix_ready held high.
- busy = 1 from INIT through the final handshake.
- done is sticky and set in the cycle after the final handshake. It is cleared by a STATUS write with bit1 = 1 or by an accepted GO. If a clear and a set coincide, set wins.
- irq = done & irq_en.
- Stall mode (MODE bit0 = 0):
  - waitrequest = cs & write & addr==2 & !release.
  - The engine starts on the first cycle of the GO write.
  - release pulses for 1 cycle after the final handshake; the GO write completes in that cycle and does not restart the engine.
  - A degenerate line still stalls for at least 2 cycles.
- Poll mode: GO never stalls.
- GO while busy: ignored; done is not cleared.
- START, END and COLOUR writes while busy: accepted and stored, but they do not affect the line in progress.
- MODE writes while busy: stored, take effect at the next GO.
- Reads and all non-GO writes: zero wait.

Optional Feature:
- Macro LDA_ACCEL_PIXCNT_EN.
- Defined:
  - address 6 reads a 32-bit count of pixels handshaken since the last accepted GO; it saturates at 0xFFFFFFFF;
  - the count resets to 0 on an accepted GO and on reset;
  - writes to address 6 are ignored.
- Undefined: address 6 reads 0 and no counter logic exists.

Test Plan:
- Poll mode, START=(0,0), END=(10,4), COLOUR=5, GO, pix_ready=1 → 11 pixels at consecutive cycles; first pixel (0,0) two cycles after GO, last (10,4); x increments by 1 every pixel; STATUS reads 0b10 afterwards; irq=1 if irq_en.
- Stall mode, START=(5,5), END=(5,0) → GO write held by waitrequest; pixels y=5..0 at x=5; write completes 1 cycle after the 6th handshake; no second line starts.
- Steep negative line START=(3,200), END=(0,190) with pix_ready toggling 1,0,1,0 → 11 pixels, each held stable while ready is low, exactly the Bresenham sequence; pixel count reads 11 with LDA_ACCEL_PIXCNT_EN.
- START=END=(318,239) → exactly one pixel (318,239); done set.
- GO while busy, plus END rewritten mid-line → current line ends at its original endpoint; second GO ignored; the next GO uses the new END.
- reset_n low mid-DRAW → pix_valid, busy, done and irq all drop immediately; MODE and coordinate registers read 0 after reset.

Source files
------------

// File: rtl/lda_accel_ms_if.sv
// Avalon-MM slave bus plus pixel valid/ready stream for lda_accel_ms.
// slave = accelerator side, master = host/sink side.
interface lda_accel_ms_if #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3
);
  logic                avs_s1_chipselect;
  logic [2:0]          avs_s1_address;
  logic                avs_s1_read;
  logic                avs_s1_write;
  logic [31:0]         avs_s1_writedata;
  logic [31:0]         avs_s1_readdata;
  logic                avs_s1_waitrequest;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic                pix_valid;
  logic                pix_ready;
  logic                irq;

  modport slave (
    input  avs_s1_chipselect, avs_s1_address, avs_s1_read, avs_s1_write,
           avs_s1_writedata, pix_ready,
    output avs_s1_readdata, avs_s1_waitrequest, pix_x, pix_y, pix_colour,
           pix_valid, irq
  );

  modport master (
    output avs_s1_chipselect, avs_s1_address, avs_s1_read, avs_s1_write,
           avs_s1_writedata, pix_ready,
    input  avs_s1_readdata, avs_s1_waitrequest, pix_x, pix_y, pix_colour,
           pix_valid, irq
  );
endinterface

// File: rtl/lda_accel_ms.sv
// lda_accel_ms: Avalon-MM Bresenham line accelerator with stall/poll GO.
// Optional pixel counter at address 6 when LDA_ACCEL_PIXCNT_EN is defined.
module lda_accel_ms #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3
) (
  input logic           csi_clockreset_clk,
  input logic           csi_clockreset_reset_n,
  lda_accel_ms_if.slave s1
);
  localparam int MW = (X_W > Y_W) ? X_W : Y_W;
  localparam int EW = MW + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;

  logic clk, rst_n;
  assign clk   = csi_clockreset_clk;
  assign rst_n = csi_clockreset_reset_n;

  logic [1:0]          state;
  logic [1:0]          mode;
  logic                line_poll;
  logic                done;
  logic                rel;
  logic [X_W-1:0]      x0_r, x1_r, cur_x, end_x;
  logic [Y_W-1:0]      y0_r, y1_r, cur_y, end_y;
  logic [COLOUR_W-1:0] colour_r, line_colour;
  logic                steep, sx, sy;
  logic signed [EW-1:0] err, major, minor;

  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        wr_en, go_wr, busy, stall_mode, go_accept, done_clr;
  logic        fire, at_end, last;
  logic [31:0] rdata, cnt_rd;
  logic        unused_wdata;

  assign addr         = s1.avs_s1_address;
  assign wdata        = s1.avs_s1_writedata;
  assign unused_wdata = ^wdata;
  assign wr_en        = s1.avs_s1_chipselect & s1.avs_s1_write;
  assign go_wr        = wr_en & (addr == 3'd2);
  assign busy         = (state != IDLE);
  // While a line runs, GO stalling follows the mode captured at its start.
  assign stall_mode   = busy ? !line_poll : !mode[0];
  assign go_accept    = go_wr & !busy & !rel;
  assign done_clr     = go_accept | (wr_en & (addr == 3'd1) & wdata[1]);
  assign fire         = (state == DRAW) & s1.pix_ready;
  assign at_end       = (cur_x == end_x) & (cur_y == end_y);
  assign last         = fire & at_end;

  assign s1.avs_s1_waitrequest = go_wr & stall_mode & !rel;
  assign s1.pix_x      = cur_x;
  assign s1.pix_y      = cur_y;
  assign s1.pix_colour = line_colour;
  assign s1.pix_valid  = (state == DRAW);
  assign s1.irq        = done & mode[1];

  // Setup terms derived from the stored endpoints during INIT
  logic signed [EW-1:0] dx, dy, adx, ady, maj_c, min_c;
  logic                 steep_c;
  assign dx      = $signed({{(EW-X_W){1'b0}}, x1_r}) - $signed({{(EW-X_W){1'b0}}, x0_r});
  assign dy      = $signed({{(EW-Y_W){1'b0}}, y1_r}) - $signed({{(EW-Y_W){1'b0}}, y0_r});
  assign adx     = dx[EW-1] ? -dx : dx;
  assign ady     = dy[EW-1] ? -dy : dy;
  assign steep_c = ady > adx;
  assign maj_c   = steep_c ? ady : adx;
  assign min_c   = steep_c ? adx : ady;

  // Stepping in place of swapping: the steep flag picks which axis is major
  logic signed [EW-1:0] err_dec;
  logic                 minor_step;
  logic [X_W-1:0]       x_step;
  logic [Y_W-1:0]       y_step;
  assign err_dec    = err - minor;
  assign minor_step = err_dec[EW-1];
  assign x_step     = sx ? cur_x - X_W'(1) : cur_x + X_W'(1);
  assign y_step     = sy ? cur_y - Y_W'(1) : cur_y + Y_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      line_poll   <= 1'b0;
      done        <= 1'b0;
      rel         <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      end_x       <= '0;
      end_y       <= '0;
      line_colour <= '0;
      steep       <= 1'b0;
      sx          <= 1'b0;
      sy          <= 1'b0;
      err         <= '0;
      major       <= '0;
      minor       <= '0;
    end else begin
      rel <= last;
      if (last)
        done <= 1'b1;
      else if (done_clr)
        done <= 1'b0;
      case (state)
        IDLE: begin
          if (go_accept) begin
            state     <= INIT;
            line_poll <= mode[0];
          end
        end
        INIT: begin
          cur_x       <= x0_r;
          cur_y       <= y0_r;
          end_x       <= x1_r;
          end_y       <= y1_r;
          line_colour <= colour_r;
          steep       <= steep_c;
          sx          <= dx[EW-1];
          sy          <= dy[EW-1];
          major       <= maj_c;
          minor       <= min_c;
          err         <= maj_c >>> 1;
          state       <= DRAW;
        end
        DRAW: begin
          if (fire) begin
            if (at_end) begin
              state <= IDLE;
            end else begin
              if (!steep || minor_step) cur_x <= x_step;
              if (steep || minor_step)  cur_y <= y_step;
              err <= minor_step ? err_dec + major : err_dec;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= '0;
      x0_r     <= '0;
      y0_r     <= '0;
      x1_r     <= '0;
      y1_r     <= '0;
      colour_r <= '0;
    end else if (wr_en) begin
      case (addr)
        3'd0: mode <= wdata[1:0];
        3'd3: begin
          x0_r <= wdata[X_W-1:0];
          y0_r <= wdata[X_W+Y_W-1:X_W];
        end
        3'd4: begin
          x1_r <= wdata[X_W-1:0];
          y1_r <= wdata[X_W+Y_W-1:X_W];
        end
        3'd5: colour_r <= wdata[COLOUR_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef LDA_ACCEL_PIXCNT_EN
  logic [31:0] pix_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pix_cnt <= '0;
    else if (go_accept)
      pix_cnt <= '0;
    else if (fire && (pix_cnt != '1))
      pix_cnt <= pix_cnt + 32'd1;
  end
  assign cnt_rd = pix_cnt;
`else
  assign cnt_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    if (s1.avs_s1_chipselect && s1.avs_s1_read) begin
      case (addr)
        3'd0:    rdata = 32'(mode);
        3'd1:    rdata = {30'd0, done, busy};
        3'd3:    rdata = 32'({y0_r, x0_r});
        3'd4:    rdata = 32'({y1_r, x1_r});
        3'd5:    rdata = 32'(colour_r);
        3'd6:    rdata = cnt_rd;
        default: rdata = '0;
      endcase
    end
  end
  assign s1.avs_s1_readdata = rdata;

endmodule

// File: tb/tb_lda_accel_ms.sv
// Directed bench for lda_accel_ms: reference Bresenham model with a
// handshake-by-handshake comparator plus hand-computed register checks.
module tb_lda_accel_ms;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int COLOUR_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lda_accel_ms_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

  lda_accel_ms #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) dut (
    .csi_clockreset_clk    (clk),
    .csi_clockreset_reset_n(rst_n),
    .s1                    (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int qx[$], qy[$], qc[$];
  int hs_cyc[$];
  int hs_n = 0;
  logic ready_toggle = 1'b0;
  logic ready_level = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int pack(input int x, input int y);
    return (y << X_W) | x;
  endfunction

  // Textbook Bresenham: swap axes for steep lines, walk the major axis.
  function automatic void gen_line(input int ax0, input int ay0, input int ax1,
                                   input int ay1, input int col);
    int a0, b0, a1, b1, da, db, e, astep, bstep, a, b;
    bit st;
    st = iabs(ay1 - ay0) > iabs(ax1 - ax0);
    if (st) begin a0 = ay0; b0 = ax0; a1 = ay1; b1 = ax1; end
    else    begin a0 = ax0; b0 = ay0; a1 = ax1; b1 = ay1; end
    da = iabs(a1 - a0);
    db = iabs(b1 - b0);
    e = da / 2;
    astep = (a1 >= a0) ? 1 : -1;
    bstep = (b1 >= b0) ? 1 : -1;
    a = a0;
    b = b0;
    for (int i = 0; i <= da; i++) begin
      if (st) begin qx.push_back(b); qy.push_back(a); end
      else    begin qx.push_back(a); qy.push_back(b); end
      qc.push_back(col);
      e -= db;
      if (e < 0) begin b += bstep; e += da; end
      a += astep;
    end
  endfunction

  // Comparator: every handshake against the model; holds must not move.
  initial begin
    logic hold;
    int hx, hy, hc;
    hold = 1'b0;
    hx = 0; hy = 0; hc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", bus.pix_valid, 1);
          check("hold_x", bus.pix_x, hx);
          check("hold_y", bus.pix_y, hy);
          check("hold_colour", bus.pix_colour, hc);
        end
        if (bus.pix_valid && bus.pix_ready) begin
          hs_n++;
          hs_cyc.push_back(cyc);
          if (qx.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pixel: got (%0d,%0d) expected none",
                     bus.pix_x, bus.pix_y);
          end else begin
            check("pix_x", bus.pix_x, qx.pop_front());
            check("pix_y", bus.pix_y, qy.pop_front());
            check("pix_colour", bus.pix_colour, qc.pop_front());
          end
        end
        hold = bus.pix_valid && !bus.pix_ready;
        hx = bus.pix_x;
        hy = bus.pix_y;
        hc = bus.pix_colour;
      end
    end
  end

  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready = ready_toggle ? !bus.pix_ready : ready_level;
    end
  end

  task automatic av_write(input logic [2:0] a, input logic [31:0] d,
                          output int waits, output int cdone);
    bus.avs_s1_chipselect = 1'b1;
    bus.avs_s1_write      = 1'b1;
    bus.avs_s1_address    = a;
    bus.avs_s1_writedata  = d;
    waits = 0;
    @(negedge clk);
    while (bus.avs_s1_waitrequest && waits < 1000) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 1000) begin
      tests++;
      fails++;
      $display("FAIL write_timeout: got %0d wait cycles expected under 1000", waits);
    end
    cdone = cyc;
    @(posedge clk);
    #1;
    bus.avs_s1_chipselect = 1'b0;
    bus.avs_s1_write      = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int w, c;
    av_write(a, d, w, c);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input longint exp);
    bus.avs_s1_chipselect = 1'b1;
    bus.avs_s1_read       = 1'b1;
    bus.avs_s1_address    = a;
    @(negedge clk);
    check(name, bus.avs_s1_readdata, exp);
    @(posedge clk);
    #1;
    bus.avs_s1_chipselect = 1'b0;
    bus.avs_s1_read       = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(negedge clk);
    while ((qx.size() != 0 || bus.pix_valid) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pixels outstanding expected 0", qx.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setup_line(input int x0, input int y0, input int x1, input int y1,
                            input int col);
    wr(3'd3, pack(x0, y0));
    wr(3'd4, pack(x1, y1));
    wr(3'd5, col);
    hs_n = 0;
    hs_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int w, c;
    bus.avs_s1_chipselect = 1'b0;
    bus.avs_s1_read       = 1'b0;
    bus.avs_s1_write      = 1'b0;
    bus.avs_s1_address    = '0;
    bus.avs_s1_writedata  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_pix_valid", bus.pix_valid, 0);
    check("rst_irq", bus.irq, 0);
    check("rst_waitreq", bus.avs_s1_waitrequest, 0);
    rd_chk("rst_mode", 3'd0, 0);
    rd_chk("rst_status", 3'd1, 0);
    rd_chk("rst_start", 3'd3, 0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd_chk("addr7_read", 3'd7, 0);

    // Poll mode, shallow line with irq enabled
    wr(3'd0, 3);
    rd_chk("mode_rw", 3'd0, 3);
    setup_line(0, 0, 10, 4, 5);
    rd_chk("end_rw", 3'd4, (4 << 9) | 10);
    gen_line(0, 0, 10, 4, 5);
    check("model_len_a", qx.size(), 11);
    check("model_a_y2", qy[2], 1);
    check("model_a_y5", qy[5], 2);
    check("model_a_last", qx[10] * 1000 + qy[10], 10004);
    av_write(3'd2, 0, w, c);
    check("poll_go_waits", w, 0);
    drain();
    check("a_count", hs_n, 11);
    check("a_first_lat", hs_cyc[0], c + 2);
    check("a_last_lat", hs_cyc[10], c + 12);
    rd_chk("a_status", 3'd1, 2);
    check("a_irq", bus.irq, 1);
`ifdef LDA_ACCEL_PIXCNT_EN
    rd_chk("a_pixcnt", 3'd6, 11);
`else
    rd_chk("a_pixcnt", 3'd6, 0);
`endif
    wr(3'd1, 2);
    rd_chk("a_status_clr", 3'd1, 0);
    check("a_irq_clr", bus.irq, 0);

    // Stall mode vertical line, irq disabled
    wr(3'd0, 0);
    setup_line(5, 5, 5, 0, 2);
    gen_line(5, 5, 5, 0, 2);
    check("model_len_b", qx.size(), 6);
    av_write(3'd2, 0, w, c);
    check("b_waits", w, 8);
    check("b_release", c, hs_cyc[5] + 1);
    repeat (10) @(posedge clk);
    #1;
    check("b_count", hs_n, 6);
    rd_chk("b_status", 3'd1, 2);
    check("b_irq_masked", bus.irq, 0);

    // Steep negative line with ready toggling
    wr(3'd0, 1);
    setup_line(3, 200, 0, 190, 6);
    gen_line(3, 200, 0, 190, 6);
    check("model_len_c", qx.size(), 11);
    check("model_c_x2", qx[2], 2);
    check("model_c_x6", qx[6], 1);
    check("model_c_x9", qx[9], 0);
    ready_toggle = 1'b1;
    wr(3'd2, 0);
    drain();
    ready_toggle = 1'b0;
    ready_level  = 1'b1;
    @(posedge clk);
    #1;
    check("c_count", hs_n, 11);
`ifdef LDA_ACCEL_PIXCNT_EN
    rd_chk("c_pixcnt", 3'd6, 11);
`else
    rd_chk("c_pixcnt", 3'd6, 0);
`endif

    // Degenerate line in stall mode
    wr(3'd0, 0);
    setup_line(318, 239, 318, 239, 7);
    gen_line(318, 239, 318, 239, 7);
    av_write(3'd2, 0, w, c);
    check("d_waits", w, 3);
    repeat (4) @(posedge clk);
    #1;
    check("d_count", hs_n, 1);
    check("d_qempty", qx.size(), 0);
    rd_chk("d_status", 3'd1, 2);

    // GO while busy and END rewritten mid-line
    wr(3'd0, 1);
    setup_line(0, 0, 20, 0, 1);
    gen_line(0, 0, 20, 0, 1);
    wr(3'd2, 0);
    wr(3'd4, pack(0, 7));
    rd_chk("e_busy", 3'd1, 1);
    wr(3'd2, 0);
    rd_chk("e_end_stored", 3'd4, 7 << 9);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("e_count", hs_n, 21);
    rd_chk("e_status", 3'd1, 2);
    hs_n = 0;
    gen_line(0, 0, 0, 7, 1);
    wr(3'd2, 0);
    drain();
    check("e_next_count", hs_n, 8);

    // Asynchronous reset mid-line
    wr(3'd0, 3);
    setup_line(0, 0, 100, 50, 4);
    gen_line(0, 0, 100, 50, 4);
    wr(3'd2, 0);
    repeat (3) @(posedge clk);
    #1;
    rd_chk("f_busy", 3'd1, 1);
    check("f_valid_pre", bus.pix_valid, 1);
    #2;
    rst_n = 1'b0;
    qx.delete();
    qy.delete();
    qc.delete();
    #1;
    check("f_valid_rst", bus.pix_valid, 0);
    check("f_irq_rst", bus.irq, 0);
    bus.avs_s1_chipselect = 1'b1;
    bus.avs_s1_read       = 1'b1;
    bus.avs_s1_address    = 3'd1;
    #1;
    check("f_status_rst", bus.avs_s1_readdata, 0);
    bus.avs_s1_chipselect = 1'b0;
    bus.avs_s1_read       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_chk("f_mode", 3'd0, 0);
    rd_chk("f_start", 3'd3, 0);
    rd_chk("f_end", 3'd4, 0);
    rd_chk("f_colour", 3'd5, 0);
    repeat (3) @(posedge clk);
    #1;
    check("f_no_pixels", bus.pix_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
